// File: rtl/col_cfg_sequencer.sv
// Control-plane sequencer for the dual-pixel colour-reduce datapath: it keeps a shadow table of
// per-channel levels and, once per requested frame boundary, programs each channel with one change strobe.
module col_cfg_sequencer #(
   parameter int         NUM_CH  = 3,
   parameter int         SETTLE  = 2,
   parameter logic [2:0] DEF_VAL = 3'd7
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cfg_we,
   input  logic [1:0] cfg_addr,
   input  logic [2:0] cfg_data,
   input  logic       apply_req,
   input  logic       frame_start,
   output logic [1:0] switch_sels,
   output logic [2:0] switch_vals,
   output logic       change,
   output logic       busy,
   output logic       applied
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_FRAME,
      S_SETUP,
      S_STROBE,
      S_SETTLE,
      S_DONE
   } state_t;

   state_t     state, state_n;
   logic [1:0] ch, ch_n;
   logic [7:0] cnt, cnt_n;
   logic       pending, pending_n;
   logic       snap_take;
   logic       change_n, busy_n, applied_n;

   // Four slots always exist so a 2-bit index can never fall outside the arrays;
   // slots at or above NUM_CH are never written and never programmed.
   logic [2:0] shadow   [4];
   logic [2:0] shadow_n [4];
   logic [2:0] snap     [4];

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         if (cfg_we && (int'(cfg_addr) == i) && (int'(cfg_addr) < NUM_CH))
            shadow_n[i] = cfg_data;
         else
            shadow_n[i] = shadow[i];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= S_IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n   = state;
      ch_n      = ch;
      cnt_n     = cnt;
      pending_n = pending;
      snap_take = 1'b0;

      case (state)
         S_IDLE: begin
            // frame_start is deliberately ignored here: the frame that coincides with
            // a request is too early to count as the boundary for that request.
            if (apply_req || pending) begin
               state_n   = S_WAIT_FRAME;
               pending_n = 1'b0;
            end
         end
         S_WAIT_FRAME: begin
            if (frame_start) begin
               state_n   = S_SETUP;
               ch_n      = 2'd0;
               snap_take = 1'b1;
            end
         end
         S_SETUP: begin
            state_n = S_STROBE;
         end
         S_STROBE: begin
            state_n = S_SETTLE;
            cnt_n   = 8'(SETTLE - 1);
         end
         S_SETTLE: begin
            if (cnt == 8'd0) begin
               if (ch == 2'(NUM_CH - 1)) begin
                  state_n = S_DONE;
               end else begin
                  state_n = S_SETUP;
                  ch_n    = ch + 2'd1;
               end
            end else begin
               cnt_n = cnt - 8'd1;
            end
         end
         S_DONE: begin
            state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase

      // Requests arriving mid-run coalesce into a single re-run from IDLE.
      if ((state != S_IDLE) && apply_req)
         pending_n = 1'b1;

      change_n  = (state_n == S_STROBE);
      busy_n    = (state_n != S_IDLE);
      applied_n = (state_n == S_DONE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ch          <= 2'd0;
         cnt         <= 8'd0;
         pending     <= 1'b0;
         switch_sels <= 2'd0;
         switch_vals <= 3'd0;
         change      <= 1'b0;
         busy        <= 1'b0;
         applied     <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            shadow[i] <= DEF_VAL;
            snap[i]   <= DEF_VAL;
         end
      end else begin
         ch      <= ch_n;
         cnt     <= cnt_n;
         pending <= pending_n;
         change  <= change_n;
         busy    <= busy_n;
         applied <= applied_n;
         for (int i = 0; i < 4; i++) begin
            shadow[i] <= shadow_n[i];
            if (snap_take)
               snap[i] <= shadow_n[i];
         end
         // sels/vals stay put outside SETUP, so IDLE keeps the last programmed pair.
         if (state == S_SETUP) begin
            switch_sels <= ch;
            switch_vals <= snap[ch];
         end
      end
   end

endmodule

// File: tb/tb_col_cfg_sequencer.sv
// Bench for col_cfg_sequencer: per-cycle vector table for full runs, plus hand-written
// sequences for coalesced requests and reset abort.
module tb_col_cfg_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       cfg_we;
   logic [1:0] cfg_addr;
   logic [2:0] cfg_data;
   logic       apply_req;
   logic       frame_start;
   logic [1:0] switch_sels;
   logic [2:0] switch_vals;
   logic       change;
   logic       busy;
   logic       applied;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   col_cfg_sequencer #(.NUM_CH(3), .SETTLE(2), .DEF_VAL(3'd7)) dut (
      .clk         (clk),
      .reset       (reset),
      .cfg_we      (cfg_we),
      .cfg_addr    (cfg_addr),
      .cfg_data    (cfg_data),
      .apply_req   (apply_req),
      .frame_start (frame_start),
      .switch_sels (switch_sels),
      .switch_vals (switch_vals),
      .change      (change),
      .busy        (busy),
      .applied     (applied)
   );

   typedef struct {
      logic       we;
      logic [1:0] addr;
      logic [2:0] data;
      logic       ap;
      logic       fr;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs[$];

   // Strobe recorder: every change pulse and applied pulse, plus adjacency violations.
   logic [4:0] strobes[$];
   int         applied_cnt = 0;
   int         adjacent    = 0;
   logic       prev_change = 1'b0;

   always @(negedge clk) begin
      if (change)
         strobes.push_back({switch_sels, switch_vals});
      if (applied)
         applied_cnt <= applied_cnt + 1;
      if (change && prev_change)
         adjacent <= adjacent + 1;
      prev_change <= change;
   end

   function automatic logic [7:0] outs();
      return {switch_sels, switch_vals, change, busy, applied};
   endfunction

   function automatic logic [7:0] pk(input logic [1:0] s, input logic [2:0] v,
                                     input logic c, input logic b, input logic a);
      return {s, v, c, b, a};
   endfunction

   function automatic void add(input logic we, input logic [1:0] addr, input logic [2:0] data,
                               input logic ap, input logic fr, input logic [7:0] exp);
      vec_t v;
      v.we = we; v.addr = addr; v.data = data; v.ap = ap; v.fr = fr; v.exp = exp;
      vecs.push_back(v);
   endfunction

   // Rows for edges E1..E13 of a run programming (0,a), (1,b), (2,c) with SETTLE=2.
   function automatic void add_run(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
      add(0, 0, 0, 0, 0, pk(2'd0, a, 1, 1, 0));
      for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 0, pk(2'd0, a, 0, 1, 0));
      add(0, 0, 0, 0, 0, pk(2'd1, b, 1, 1, 0));
      for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 0, pk(2'd1, b, 0, 1, 0));
      add(0, 0, 0, 0, 0, pk(2'd2, c, 1, 1, 0));
      for (int k = 0; k < 2; k++) add(0, 0, 0, 0, 0, pk(2'd2, c, 0, 1, 0));
      add(0, 0, 0, 0, 0, pk(2'd2, c, 0, 1, 1));
      add(0, 0, 0, 0, 0, pk(2'd2, c, 0, 0, 0));
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got sels/vals/chg/busy/appl=%b expected %b", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_strobe(input string name, input int idx, input logic [4:0] exp);
      logic [4:0] act;
      act = (idx < strobes.size()) ? strobes[idx] : 5'h1f;
      checks++;
      if (idx >= strobes.size() || act !== exp) begin
         failures++;
         $display("FAIL %s: got strobe (sels,vals)=%b (count %0d) expected %b",
                  name, act, strobes.size(), exp);
      end
   endtask

   task automatic cyc(input logic we, input logic [1:0] a, input logic [2:0] d,
                      input logic ap, input logic fr);
      cfg_we = we; cfg_addr = a; cfg_data = d; apply_req = ap; frame_start = fr;
      @(posedge clk);
      #1;
      cfg_we = 1'b0; cfg_addr = 2'd0; cfg_data = 3'd0; apply_req = 1'b0; frame_start = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0);
   endtask

   int base_s;
   int base_a;

   initial begin
      reset = 1'b0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_data = 3'd0;
      apply_req = 1'b0; frame_start = 1'b0;

      // Default-level run, then written levels (addr 3 ignored), then apply+frame same cycle.
      add(0, 0, 0, 1, 0, pk(0, 0, 0, 1, 0));
      for (int k = 0; k < 4; k++) add(0, 0, 0, 0, 0, pk(0, 0, 0, 1, 0));
      add(0, 0, 0, 0, 1, pk(0, 0, 0, 1, 0));
      add_run(3'd7, 3'd7, 3'd7);
      add(0, 0, 0, 0, 0, pk(2, 7, 0, 0, 0));
      add(1, 0, 2, 0, 0, pk(2, 7, 0, 0, 0));
      add(1, 1, 5, 0, 0, pk(2, 7, 0, 0, 0));
      add(1, 2, 1, 0, 0, pk(2, 7, 0, 0, 0));
      add(1, 3, 6, 0, 0, pk(2, 7, 0, 0, 0));
      add(0, 0, 0, 1, 0, pk(2, 7, 0, 1, 0));
      add(0, 0, 0, 0, 1, pk(2, 7, 0, 1, 0));
      add_run(3'd2, 3'd5, 3'd1);
      add(0, 0, 0, 1, 1, pk(2, 1, 0, 1, 0));
      for (int k = 0; k < 5; k++) add(0, 0, 0, 0, 0, pk(2, 1, 0, 1, 0));
      add(0, 0, 0, 0, 1, pk(2, 1, 0, 1, 0));
      add_run(3'd2, 3'd5, 3'd1);

      repeat (3) @(posedge clk);
      #1;
      check("reset_held", outs(), 8'd0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("reset_released_idle", outs(), 8'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         cyc(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].ap, vecs[i].fr);
         check($sformatf("vec%0d", i), outs(), vecs[i].exp);
      end

      // Mid-run write to shadow[2] plus two apply pulses: one coalesced re-run.
      base_s = strobes.size();
      base_a = applied_cnt;
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 1);
      idle(2);
      cyc(1, 2, 0, 1, 0);
      idle(1);
      cyc(0, 0, 0, 1, 0);
      idle(7);
      check("t4_first_applied", outs(), pk(2, 1, 0, 1, 1));
      idle(1);
      check("t4_idle_gap", outs(), pk(2, 1, 0, 0, 0));
      idle(1);
      check("t4_rerun_waiting", outs(), pk(2, 1, 0, 1, 0));
      idle(6);
      check_int("t4_no_strobe_before_frame", strobes.size() - base_s, 3);
      cyc(0, 0, 0, 0, 1);
      idle(15);
      check("t4_rerun_done", outs(), pk(2, 0, 0, 0, 0));
      check_strobe("t4_run1_ch2_snapshot", base_s + 2, {2'd2, 3'd1});
      check_strobe("t4_run2_ch0", base_s + 3, {2'd0, 3'd2});
      check_strobe("t4_run2_ch1", base_s + 4, {2'd1, 3'd5});
      check_strobe("t4_run2_ch2", base_s + 5, {2'd2, 3'd0});
      check_int("t4_strobe_count", strobes.size() - base_s, 6);
      check_int("t4_applied_count", applied_cnt - base_a, 2);

      // Reset pulse during SETTLE of channel 1 aborts the run and restores defaults.
      base_s = strobes.size();
      base_a = applied_cnt;
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 1);
      idle(6);
      check("t5_in_settle_ch1", outs(), pk(1, 5, 0, 1, 0));
      #2;
      reset = 1'b0;
      #1;
      check("t5_async_clear", outs(), 8'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      idle(20);
      check("t5_quiet_after_reset", outs(), 8'd0);
      check_int("t5_no_extra_strobes", strobes.size() - base_s, 2);
      check_int("t5_no_applied", applied_cnt - base_a, 0);
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 1);
      idle(13);
      check("t5_default_run_done", outs(), pk(2, 7, 0, 0, 0));
      check_strobe("t5_default_ch0", base_s + 2, {2'd0, 3'd7});
      check_strobe("t5_default_ch1", base_s + 3, {2'd1, 3'd7});
      check_strobe("t5_default_ch2", base_s + 4, {2'd2, 3'd7});
      check_int("t5_applied_once", applied_cnt - base_a, 1);

      idle(1);
      check_int("no_adjacent_strobes", adjacent, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/col_cfg_sequencer.md
Name: col_cfg_sequencer

Overview:
- Control-plane sequencer for the dual-pixel colour-reduce datapath. It drives that datapath's switch_sels, switch_vals and change inputs.
- Holds a shadow table of per-channel reduction levels written by the UI/button logic.
- On an apply request, waits for the next frame boundary, then programs each channel in turn with a one-cycle change strobe and a settle gap. Reconfiguration therefore never lands mid-frame.
- Sits between the debounced-button/UI logic and the colour-reduce wrapper; one instance serves both pixel lanes.

Parameters:
- NUM_CH, 3, number of channels programmed (sels values 0..NUM_CH-1; max 4).
- SETTLE, 2, idle cycles after each change strobe before the next channel (>=1).
- DEF_VAL, 3'd7, reset value of every shadow level register.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- cfg_we  in  1  write strobe for the shadow table.
- cfg_addr  in  2  shadow channel index; writes with cfg_addr >= NUM_CH are ignored.
- cfg_data  in  3  level written to shadow[cfg_addr].
- apply_req  in  1  one-cycle pulse: push the shadow table to the datapath.
- frame_start  in  1  one-cycle pulse at start of vertical blanking.
- switch_sels  out  2  channel select to datapath (registered).
- switch_vals  out  3  level to datapath (registered).
- change  out  1  one-cycle load strobe to datapath (registered).
- busy  out  1  high from acceptance of a request until return to IDLE.
- applied  out  1  one-cycle pulse when the full table has been programmed.

Behaviour:
- Reset (reset=0, asynchronous):
  - shadow[*]=DEF_VAL, active snapshot = DEF_VAL, pending=0.
  - State IDLE; switch_sels=0, switch_vals=0, change=0, busy=0, applied=0.
  - Reset asserted mid-sequence aborts it immediately. No further change strobes occur after reset deasserts.
- Shadow writes:
  - cfg_we=1 with a valid address updates shadow at the edge, in any state.
  - Writes never affect a sequence already past WAIT_FRAME, because the snapshot has been taken.
- States and transitions:
  - IDLE: busy=0.
    - apply_req=1 or pending=1 -> WAIT_FRAME; clear pending.
    - frame_start in the same cycle as apply_req is NOT counted.
  - WAIT_FRAME: busy=1.
    - frame_start=1 -> SETUP with ch=0; snapshot all shadow registers at this edge.
    - A cfg_we in the same cycle is included in the snapshot (write-first).
  - SETUP: switch_sels=ch, switch_vals=snap[ch], change=0; next state STROBE.
  - STROBE: change=1; sels/vals held; next state SETTLE with counter=SETTLE-1.
  - SETTLE: change=0, sels/vals held; counter decrements.
    - At 0: if ch==NUM_CH-1 -> DONE, else SETUP with ch+1.
  - DONE: applied=1 for exactly one cycle, busy=1; next state IDLE.
- apply_req while busy (WAIT_FRAME..DONE) sets pending. Multiple requests coalesce into one re-run, which starts from IDLE on the cycle after DONE and waits for a fresh frame_start.
- frame_start outside WAIT_FRAME is ignored.
- In IDLE, switch_sels/switch_vals hold their last programmed values.
- Timing, with E0 = the edge that samples frame_start in WAIT_FRAME:
  - Channel n: change high in the cycle after edge E(n*(SETTLE+2)+1).
  - applied high in the cycle after E(NUM_CH*(SETTLE+2)).
  - busy falls after the following edge.
- Change strobes are never adjacent; there are at least SETTLE+1 low cycles between them.

Test Plan:
- Release reset, no stimulus:
  - switch_sels=0, vals=0, change=0, busy=0, applied=0.
  - Pulse apply_req, then frame_start 5 cycles later: change high after E1, E5, E9 with (sels,vals) = (0,7), (1,7), (2,7); applied after E12; busy=0 after E13.
- Write shadow {0:3'd2, 1:3'd5, 2:3'd1, addr3:3'd6} then apply + frame:
  - Strobes carry (0,2), (1,5), (2,1).
  - The addr-3 write has no effect.
- Issue apply_req and frame_start in the same cycle:
  - No strobe occurs until the next frame_start.
- During the sequence (after E2), write shadow[2]=3'd0 and pulse apply_req twice:
  - The current run still programs channel 2 with its snapshot value.
  - Exactly one re-run follows the next frame_start with (2,0); exactly two applied pulses total.
- Drop reset for one cycle during SETTLE of channel 1:
  - All outputs go to 0 asynchronously and state returns to IDLE.
  - No change pulse follows, and shadow returns to 7.
